// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module   : seq_divider_pkg
// Purpose  : Shared op and state encodings for the sequential RV32M divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    // Operation codes, identical to funct3[1:0] of the RV32M divide group
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_ripple_sub.sv
// ============================================================================
// Module   : ripple_sub
// Purpose  : Ripple-carry subtractor diff = x - y; nborrow=1 when x >= y.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ripple_sub #(
    parameter int N = 31
) (
    input  logic [N:0] x,
    input  logic [N:0] y,
    output logic [N:0] diff,
    output logic       nborrow
);

    logic [N+1:0] w_carry;

    // x + ~y + 1: the final carry out is the inverted borrow
    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i <= N; i++) begin : g_fa
        logic w_p;
        assign w_p          = x[i] ^ ~y[i];
        assign diff[i]      = w_p ^ w_carry[i];
        assign w_carry[i+1] = (x[i] & ~y[i]) | (w_carry[i] & w_p);
    end

    assign nborrow = w_carry[N+1];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient
//            bit per cycle. Macro DIV_FAST_SPECIAL_EN skips CALC for b=0 and
//            signed overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [N:0] a,
    input  logic [N:0] b,
    output logic       busy,
    output logic       done,
    output logic [N:0] result
);

    localparam int         CNT_W    = (N > 0) ? $clog2(N + 1) : 1;
    localparam logic [N:0] SIGN_MIN = {1'b1, {N{1'b0}}};

    div_state_t       r_state;
    logic [1:0]       r_op;
    logic [N:0]       r_quo;
    logic [N:0]       r_rem;
    logic [N:0]       r_b_mag;
    logic [N:0]       r_a_raw;
    logic [CNT_W-1:0] r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_div0;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic [N:0]       r_result;

    logic             w_signed;
    logic [N:0]       w_a_mag;
    logic [N:0]       w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic [N:0]       w_rem_sh;
    logic [N:0]       w_diff;
    logic             w_nborrow;
    logic             w_ge;
    logic [N:0]       w_fix_q;
    logic [N:0]       w_fix_r;
    logic [N:0]       w_fix;

    assign w_signed = op_is_signed(op);
    assign w_a_mag  = (w_signed && a[N]) ? (~a + 1'b1) : a;
    assign w_b_mag  = (w_signed && b[N]) ? (~b + 1'b1) : b;
    assign w_div0   = (b == '0);
    assign w_ovf    = w_signed && (a == SIGN_MIN) && (b == '1);

`ifdef DIV_FAST_SPECIAL_EN
    logic w_special;
    assign w_special = w_div0 | w_ovf;
`endif

    // A set remainder MSB means the shifted value exceeds any n+1-bit divisor
    assign w_rem_sh = {r_rem[N-1:0], r_quo[N]};
    assign w_ge     = w_nborrow | r_rem[N];

    ripple_sub #(.N(N)) u_sub (
        .x       (w_rem_sh),
        .y       (r_b_mag),
        .diff    (w_diff),
        .nborrow (w_nborrow)
    );

    always_comb begin
        w_fix_q = r_qneg ? (~r_quo + 1'b1) : r_quo;
        w_fix_r = r_rneg ? (~r_rem + 1'b1) : r_rem;
        if (r_div0) begin
            w_fix_q = '1;
            w_fix_r = r_a_raw;
        end else if (r_ovf) begin
            w_fix_q = r_a_raw;
            w_fix_r = '0;
        end
        w_fix = op_is_rem(r_op) ? w_fix_r : w_fix_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_b_mag  <= '0;
            r_a_raw  <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_quo   <= w_a_mag;
                        r_b_mag <= w_b_mag;
                        r_a_raw <= a;
                        r_qneg  <= w_signed & (a[N] ^ b[N]);
                        r_rneg  <= w_signed & a[N];
                        r_rem   <= '0;
                        r_cnt   <= CNT_W'(N);
                        r_div0  <= w_div0;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
                        r_state <= w_special ? S_FIX : S_CALC;
`else
                        r_state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    r_quo <= {r_quo[N-1:0], w_ge};
                    r_rem <= w_ge ? w_diff : w_rem_sh;
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider with directed, hand-computed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int N = 31;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [N:0] a     = '0;
    logic [N:0] b     = '0;
    logic       busy;
    logic       done;
    logic [N:0] result;

    seq_divider #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] res;
        int         issue;
        int         lat;
        int         bcnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string nm, input logic [N:0] act, input logic [N:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: result %h with nothing outstanding", result);
                end else begin
                    e = q.pop_front();
                    check_val({e.name, "_result"}, result, e.res);
                    check_int({e.name, "_latency"}, cyc - e.issue, e.lat);
                    check_int({e.name, "_busy_cycles"}, busy_cnt, e.bcnt);
                end
                busy_cnt = 0;
            end
        end
    end

    // mode 0: single start pulse; 1: start held until done; 2: extra pulse mid-CALC
    task automatic do_op(input string nm, input logic [1:0] o, input logic [N:0] x,
                         input logic [N:0] y, input logic [N:0] r, input bit special,
                         input int mode);
        exp_t e;
        int   k;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        e.res   = r;
        e.issue = cyc + 1;
        e.name  = nm;
`ifdef DIV_FAST_SPECIAL_EN
        e.lat  = special ? 1 : N + 2;
        e.bcnt = special ? 1 : N + 2;
`else
        e.lat  = N + 2;
        e.bcnt = N + 2;
        if (special) e.name = nm;
`endif
        q.push_back(e);
        @(negedge clk);
        if (mode != 1) start = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            if (mode == 2 && k == 10) begin
                start = 1'b1; a = '1; b = 32'd1;
            end else if (mode == 2 && k == 11) begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected within 200", nm, k);
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_busy", {{N{1'b0}}, busy}, '0);
        check_val("reset_done", {{N{1'b0}}, done}, '0);
        check_val("reset_result", result, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_op("divu_100_7",   DIV_OP_DIVU, 32'd100,       32'd7,          32'h0000000E, 1'b0, 0);
        do_op("rem_m100_7",   DIV_OP_REM,  32'hFFFFFF9C,  32'd7,          32'hFFFFFFFE, 1'b0, 0);
        do_op("div_m100_7",   DIV_OP_DIV,  32'hFFFFFF9C,  32'd7,          32'hFFFFFFF2, 1'b0, 0);
        do_op("div_100_m7",   DIV_OP_DIV,  32'd100,       32'hFFFFFFF9,   32'hFFFFFFF2, 1'b0, 0);
        do_op("rem_100_m7",   DIV_OP_REM,  32'd100,       32'hFFFFFFF9,   32'h00000002, 1'b0, 0);
        do_op("div_5_0",      DIV_OP_DIV,  32'd5,         32'd0,          32'hFFFFFFFF, 1'b1, 0);
        do_op("remu_x_0",     DIV_OP_REMU, 32'h80000001,  32'd0,          32'h80000001, 1'b1, 0);
        do_op("div_ovf",      DIV_OP_DIV,  32'h80000000,  32'hFFFFFFFF,   32'h80000000, 1'b1, 0);
        do_op("rem_ovf",      DIV_OP_REM,  32'h80000000,  32'hFFFFFFFF,   32'h00000000, 1'b1, 0);
        do_op("remu_big",     DIV_OP_REMU, 32'hFFFFFFFF,  32'h80000001,   32'h7FFFFFFE, 1'b0, 0);
        do_op("divu_big",     DIV_OP_DIVU, 32'hFFFFFFFF,  32'h80000001,   32'h00000001, 1'b0, 0);
        do_op("hold_start",   DIV_OP_DIVU, 32'd1000,      32'd10,         32'h00000064, 1'b0, 1);
        do_op("mid_pulse",    DIV_OP_REMU, 32'd1000,      32'd7,          32'h00000006, 1'b0, 2);

        // Abort an operation partway through CALC
        @(negedge clk);
        op = DIV_OP_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("pre_reset_busy", {{N{1'b0}}, busy}, {{N{1'b0}}, 1'b1});
        check_val("pre_reset_result", result, 32'h00000006);
        #1 rst = 1'b0;
        #1;
        check_val("abort_busy", {{N{1'b0}}, busy}, '0);
        check_val("abort_done", {{N{1'b0}}, done}, '0);
        check_val("abort_result", result, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        do_op("divu_9_3",     DIV_OP_DIVU, 32'd9,         32'd3,          32'h00000003, 1'b0, 0);

        repeat (50) @(negedge clk);
        check_int("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
